// File: rtl/xs3_to_bcd_packer.sv
// xs3_to_bcd_packer: packs a stream of Excess-3 digits into right-aligned BCD words.
module xs3_to_bcd_packer #(
  parameter int NUM_DIGITS = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [3:0]                        in_xs3,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [4*NUM_DIGITS-1:0]           out_bcd,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   out_count,
  output logic                              out_err,
  output logic [7:0]                        err_count
);
  localparam int CW = $clog2(NUM_DIGITS + 1);
  localparam logic [CW-1:0] ND = CW'(NUM_DIGITS);
  typedef enum logic [1:0] {IDLE, ACCUM, FULL} state_t;
  state_t state, state_nx;
  logic [4*NUM_DIGITS-1:0] acc, acc_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic sticky, bad, accept, closing, err_nx;
  logic [3:0] digit;
  assign out_valid = state == FULL;
  // Held low while rst_n is asserted so no digit is offered to a resetting block.
  assign in_ready = rst_n && state != FULL;
  assign accept = in_valid && in_ready;
  always_comb begin
    bad = in_xs3 < 4'd3 || in_xs3 > 4'd12;
    digit = bad ? 4'd0 : in_xs3 - 4'd3;
    acc_nx = {acc[4*NUM_DIGITS-5:0], digit};
    cnt_nx = cnt + CW'(1);
    closing = in_last || cnt_nx == ND;
    err_nx = sticky || bad;
    state_nx = state == FULL ? (out_ready ? IDLE : FULL) :
               accept ? (closing ? FULL : ACCUM) : state;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      cnt <= '0;
      sticky <= 1'b0;
      out_bcd <= '0;
      out_count <= '0;
      out_err <= 1'b0;
      err_count <= '0;
    end else begin
      state <= state_nx;
      if (accept && closing) begin
        out_bcd <= acc_nx;
        out_count <= cnt_nx;
        out_err <= err_nx;
        acc <= '0;
        cnt <= '0;
        sticky <= 1'b0;
        if (err_nx && err_count != 8'hff) err_count <= err_count + 8'd1;
      end else if (accept) begin
        acc <= acc_nx;
        cnt <= cnt_nx;
        sticky <= err_nx;
      end
    end
  end
endmodule
